// File: rtl/xc_aesmix_state.sv
// xc_aesmix_state
//   Iterative AES MixColumns (forward or inverse) over a full state of NCOL
//   32-bit columns, computing LANES columns per cycle. Uses the XCrypto
//   valid/ready/flush handshake so it can be issued as a multi-cycle
//   functional-unit operation.
//
// Parameters
//   NCOL   number of 32-bit columns in the state (>= 1)
//   LANES  columns computed per cycle; must divide NCOL (G = NCOL/LANES groups)
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   flush     in   abort any operation in progress, return to IDLE
//   valid     in   request valid; inputs held stable until ready
//   state_in  in   32*NCOL state, column c = bits [32c+31:32c], byte 0 = [7:0]
//   enc       in   1 = forward MixColumns, 0 = inverse MixColumns
//   ready     out  single-cycle pulse, result valid
//   result    out  32*NCOL mixed state, same layout as state_in
module xc_aesmix_state #(
  parameter int NCOL  = 4,
  parameter int LANES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  valid,
  input  logic [32*NCOL-1:0]    state_in,
  input  logic                  enc,
  output logic                  ready,
  output logic [32*NCOL-1:0]    result
);

  localparam int NG    = (LANES > 0) ? (NCOL / LANES) : 1;
  localparam int IDX_W = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NG - 1);

  if ((NCOL < 1) || (LANES < 1) || ((NCOL % LANES) != 0)) begin : gBadParams
    $error("xc_aesmix_state: LANES must be >= 1 and divide NCOL exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                 state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [32*NCOL-1:0]    result_q, result_d;
  logic                  compute;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse MixColumns matrix. All the
  // needed multiples are built from a shared xtime chain (2a, 4a, 8a).
  function automatic logic [31:0] mixColumn(input logic [31:0] col, input logic fwd);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11[4];
    logic [7:0] m13[4];
    logic [7:0] m14[4];
    logic [7:0] m4, m8;
    logic [7:0] b  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[8*i +: 8];
      m2[i]  = xtime(a[i]);
      m4     = xtime(m2[i]);
      m8     = xtime(m4);
      m3[i]  = m2[i] ^ a[i];
      m9[i]  = m8 ^ a[i];
      m11[i] = m8 ^ m2[i] ^ a[i];
      m13[i] = m8 ^ m4 ^ a[i];
      m14[i] = m8 ^ m4 ^ m2[i];
    end
    if (fwd) begin
      b[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
      b[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
      b[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
      b[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
    end else begin
      b[0] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
      b[1] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
      b[2] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
      b[3] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end
    mixColumn = {b[3], b[2], b[1], b[0]};
  endfunction

  // State, group counter and result register. Reset wins over everything,
  // including flush and an operation in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // Next-state logic. idx_q is always zero in IDLE, so the group being
  // computed is simply idx_q in both IDLE and BUSY. Dropping valid in BUSY
  // abandons the operation without a ready pulse; flush does the same from
  // any state but leaves the result register untouched.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    compute  = 1'b0;

    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            compute = 1'b1;
            if (NG == 1) begin
              state_d = DONE;
            end else begin
              state_d = BUSY;
              idx_d   = IDX_W'(1);
            end
          end
        end
        BUSY: begin
          if (!valid) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            compute = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end

    if (compute) begin
      for (int l = 0; l < LANES; l++) begin
        result_d[(int'(idx_q) * LANES + l) * 32 +: 32] =
          mixColumn(state_in[(int'(idx_q) * LANES + l) * 32 +: 32], enc);
      end
    end
  end

  assign ready  = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_xc_aesmix_state.sv
// tb_xc_aesmix_state
//   Exercises two instances of xc_aesmix_state: a serial one (NCOL=4,
//   LANES=1, four groups) and a parallel one (NCOL=4, LANES=4, one group).
//   Directed vectors cover the known MixColumns answers, latency, back-to-back
//   issue, flush and mid-operation reset; random states are then checked
//   against a GF(2^8) matrix model.
module tb_xc_aesmix_state;

  localparam int NCOL = 4;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              enc;
  logic [32*NCOL-1:0] stateIn;
  logic              validA, validB;
  logic              readyA, readyB;
  logic [32*NCOL-1:0] resultA, resultB;

  int checkCount;
  int passCount;
  int failCount;

  xc_aesmix_state #(.NCOL(NCOL), .LANES(1)) dutSerial (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .valid    (validA),
    .state_in (stateIn),
    .enc      (enc),
    .ready    (readyA),
    .result   (resultA)
  );

  xc_aesmix_state #(.NCOL(NCOL), .LANES(4)) dutParallel (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .valid    (validB),
    .state_in (stateIn),
    .enc      (enc),
    .ready    (readyB),
    .result   (resultB)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference GF(2^8) multiply, shift-and-add modulo 0x11b.
  function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = x;
    bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Reference MixColumns as a circulant matrix product on each column.
  function automatic logic [127:0] refMix(input logic [127:0] st, input logic fwd);
    logic [7:0]   row0 [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (fwd) begin
      row0[0] = 8'd2;  row0[1] = 8'd3;  row0[2] = 8'd1;  row0[3] = 8'd1;
    end else begin
      row0[0] = 8'd14; row0[1] = 8'd11; row0[2] = 8'd13; row0[3] = 8'd9;
    end
    res = '0;
    for (int c = 0; c < NCOL; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gfMul(row0[(j - i + 4) % 4], st[32*c + 8*j +: 8]);
        end
        res[32*c + 8*i +: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic getReady(input int which);
    return (which == 0) ? readyA : readyB;
  endfunction

  function automatic logic [127:0] getResult(input int which);
    return (which == 0) ? resultA : resultB;
  endfunction

  // From cycle 0 (valid already driven) step to cycle lat, checking ready is
  // low before and high at lat, then checking result at lat.
  task automatic waitReady(input int which, input int lat, input logic [127:0] exp, input string tag);
    for (int k = 1; k <= lat; k++) begin
      stepCycle();
      checkOutput($sformatf("%s.ready@%0d", tag, k), 128'(getReady(which)), 128'(k == lat));
    end
    checkOutput({tag, ".result"}, getResult(which), exp);
  endtask

  // One complete operation on the selected instance, ending back in IDLE.
  task automatic applyStimulus(input int which, input logic [127:0] st, input logic e,
                               input logic [127:0] exp, input string tag);
    stateIn = st;
    enc     = e;
    if (which == 0) validA = 1'b1; else validB = 1'b1;
    waitReady(which, (which == 0) ? 4 : 1, exp, tag);
    validA = 1'b0;
    validB = 1'b0;
    stepCycle();
  endtask

  localparam logic [127:0] VEC_IN  = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] VEC_OUT = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [127:0] B2B_IN1  = {4{32'hd5d4d4d4}};
  localparam logic [127:0] B2B_OUT1 = {4{32'hd6d7d5d5}};
  localparam logic [127:0] B2B_IN2  = {4{32'h4c31262d}};
  localparam logic [127:0] B2B_OUT2 = {4{32'hf8bd7e4d}};

  initial begin
    logic [127:0] rnd;
    logic         rndEnc;
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    reset   = 1'b0;
    flush   = 1'b0;
    enc     = 1'b1;
    validA  = 1'b0;
    validB  = 1'b0;
    stateIn = '0;

    // Reset state.
    stepCycle();
    stepCycle();
    checkOutput("rst.readyA",  128'(readyA), 128'(0));
    checkOutput("rst.resultA", resultA, '0);
    checkOutput("rst.readyB",  128'(readyB), 128'(0));
    checkOutput("rst.resultB", resultB, '0);
    reset = 1'b1;
    stepCycle();

    // Forward and inverse on the serial instance, then the parallel one.
    applyStimulus(0, VEC_IN,  1'b1, VEC_OUT, "fwdG4");
    applyStimulus(0, VEC_OUT, 1'b0, VEC_IN,  "invG4");
    applyStimulus(1, VEC_IN,  1'b1, VEC_OUT, "fwdG1");

    // Parallel with valid held: ready at cycles 1, 3, 5.
    stateIn = VEC_IN;
    enc     = 1'b1;
    validB  = 1'b1;
    waitReady(1, 1, VEC_OUT, "b2bG1a");
    stepCycle();
    checkOutput("b2bG1.ready@2", 128'(readyB), 128'(0));
    waitReady(1, 1, VEC_OUT, "b2bG1b");
    stepCycle();
    checkOutput("b2bG1.ready@4", 128'(readyB), 128'(0));
    waitReady(1, 1, VEC_OUT, "b2bG1c");
    validB = 1'b0;
    stepCycle();

    // Back-to-back on the serial instance: second op inputs at cycle 5.
    stateIn = B2B_IN1;
    enc     = 1'b1;
    validA  = 1'b1;
    waitReady(0, 4, B2B_OUT1, "b2bG4a");
    stepCycle();
    checkOutput("b2bG4.ready@5", 128'(readyA), 128'(0));
    stateIn = B2B_IN2;
    waitReady(0, 4, B2B_OUT2, "b2bG4b");
    validA = 1'b0;
    stepCycle();

    // Flush at cycle 2 with valid held; restart from cycle 3, ready at 7.
    stateIn = B2B_IN2;
    enc     = 1'b1;
    validA  = 1'b1;
    stepCycle();
    stepCycle();
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("flush.ready@3", 128'(readyA), 128'(0));
    waitReady(0, 4, B2B_OUT2, "flush.restart");
    validA = 1'b0;
    stepCycle();

    // Reset at cycle 2; cycle 3 must show a cleared unit.
    stateIn = VEC_IN;
    enc     = 1'b1;
    validA  = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    reset = 1'b1;
    checkOutput("rstMid.ready@3",  128'(readyA), 128'(0));
    checkOutput("rstMid.resultA",  resultA, '0);
    checkOutput("rstMid.resultB",  resultB, '0);
    waitReady(0, 4, VEC_OUT, "rstMid.restart");
    validA = 1'b0;
    stepCycle();

    // Random states and directions on both instances against the model.
    for (int n = 0; n < 12; n++) begin
      rnd    = {$urandom, $urandom, $urandom, $urandom};
      rndEnc = 1'($urandom_range(0, 1));
      applyStimulus(0, rnd, rndEnc, refMix(rnd, rndEnc), $sformatf("rndA%0d", n));
      rnd    = {$urandom, $urandom, $urandom, $urandom};
      rndEnc = 1'($urandom_range(0, 1));
      applyStimulus(1, rnd, rndEnc, refMix(rnd, rndEnc), $sformatf("rndB%0d", n));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/xc_aesmix_state.md
# xc_aesmix_state

Parametrised successor to the single-column AES MixColumns unit. Applies forward or inverse MixColumns to a full AES state of `NCOL` 32-bit columns, processing `LANES` columns per cycle through a small iterative datapath. Sits beside the XCrypto AES instruction units. Uses the same valid/ready/flush handshake, so it can be issued as a multi-cycle functional-unit operation.

## Interface
- `NCOL`, 4, number of 32-bit columns in the state; must be ≥1.
- `LANES`, 1, columns computed per cycle; must divide `NCOL` exactly; G = NCOL/LANES groups.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `flush`  in  1  abort any operation in progress; return to IDLE.
- `valid`  in  1  inputs valid; held with inputs stable until `ready`.
- `state_in`  in  32*NCOL  column c = bits [32c+31:32c]; byte 0 of a column = bits [7:0].
- `enc`  in  1  1 = forward MixColumns; 0 = inverse MixColumns.
- `ready`  out  1  result valid; single-cycle pulse.
- `result`  out  32*NCOL  mixed state; same column/byte layout as `state_in`.

## Operation
- Per lane, combinational over column bytes a0..a3, with GF(2^8) polynomial 0x11b:
  - Forward: b0=2a0^3a1^a2^a3; b1=a0^2a1^3a2^a3; b2=a0^a1^2a2^3a3; b3=3a0^a1^a2^2a3.
  - Inverse: b0=14a0^11a1^13a2^9a3; b1=9a0^14a1^11a2^13a3; b2=13a0^9a1^14a2^11a3; b3=11a0^13a1^9a2^14a3.
- Group counter `idx`: width max(1, clog2(G)). Group k covers columns k*LANES .. k*LANES+LANES-1.
- Lane inputs are taken from `state_in`, selected by `idx`. Lane outputs are written into the matching columns of the `result` register.
- FSM states:
  - IDLE: if `valid` and not `flush`, compute group 0. If G=1 → DONE; else → BUSY with `idx`=1.
  - BUSY: compute group `idx`. If `idx`=G-1 → DONE and clear `idx`; else increment `idx`.
  - DONE: `ready`=1; → IDLE unconditionally.
- Each group reads `enc` and `state_in` live. Both must remain stable from the first valid cycle through the `ready` cycle.
- `valid` deasserted in BUSY: abort → IDLE, `idx`=0, no `ready`.
- `flush` high in any state → IDLE, `idx`=0, next cycle. `flush` takes priority over `valid` in IDLE. The `result` register is not cleared by `flush`.
- `flush` asserted in the DONE cycle, i.e. the consumer's `valid && ready`: no effect beyond the normal return to IDLE.
- Columns not yet written in the current operation hold stale data. `result` is defined only while `ready`=1.
- Invalid parameters (`NCOL % LANES` ≠ 0): elaboration-time error.

## Timing
- Reset (`reset`=0 at an edge):
  - FSM → IDLE, `idx`=0, `ready`=0, `result`=0.
  - Overrides `flush` and `valid`, including mid-operation.
- Latency: `valid` first seen in IDLE at cycle 0 → group k computed at cycle k → `ready`=1 at cycle G.
  - `ready` is registered (driven from the DONE state). No combinational path from inputs to `ready` or `result`.
- Throughput: one state per G+1 cycles. With `valid` held high, the next operation starts at cycle G+1.
- Back-to-back with G=1: `ready` at cycles 1, 3, 5, ...

## Test plan
Column vectors below are listed as bytes a0..a3.

- **Forward, G=4** (`NCOL`=4, `LANES`=1), `enc`=1:
  - Stimulus columns: db135345, f20a225c, 01010101, c6c6c6c6.
  - Required: `ready` only at cycle 4; `result` columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6.
- **Inverse, G=4**, `enc`=0, on the four output columns of the forward test:
  - Required: original inputs recovered; `ready` at cycle 4.
- **Parallel** (`LANES`=4, G=1): same vectors as the forward test.
  - Required: `ready` at cycle 1, identical `result`.
  - Additionally, with `valid` held high, `ready` at cycles 1, 3, 5.
- **Back-to-back, G=4**:
  - Op 1: columns d4d4d4d5 ×4 → d5d5d7d6 ×4, `ready` at cycle 4.
  - Op 2: new inputs 2d26314c ×4 at cycle 5 → 4d7ebdf8 ×4, `ready` at cycle 9.
- **Flush**: `flush`=1 at cycle 2 of a G=4 operation.
  - Required: no `ready` in cycles 3–6; FSM in IDLE at cycle 3.
  - Restarting at cycle 3 gives correct `result` with `ready` at cycle 7.
- **Reset mid-op**: `reset`=0 at cycle 2.
  - Required: cycle 3 shows `ready`=0, `result`=0.
  - After `reset`=1, a new operation completes with latency 4.
